// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the controller FSM encoding and the default exception entry point.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } ctrl_state_t;

   localparam logic [31:0] DEFAULT_EXC_VEC = 32'hBFC0_0380;

endpackage : pipe_ctrl_pkg

// File: rtl/stall_watchdog.sv
// Saturating count of consecutive stalled cycles with a registered timeout flag.
// The flag stays high while the count sits at MAX_HOLD and drops once stalls stop.
module stall_watchdog #(
   parameter int MAX_HOLD = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic stall_active,
   input  logic clear,
   output logic hold_timeout
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [HOLD_W-1:0] hold_cnt_next;
   logic              hold_timeout_reg;

   always_comb begin
      hold_cnt_next = hold_cnt_reg;
      if (clear) begin
         hold_cnt_next = '0;
      end else if (stall_active && (hold_cnt_reg != HOLD_MAX)) begin
         hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
      end
   end

   // Timeout is derived from the next count so it tracks the counter register exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_cnt_reg     <= '0;
         hold_timeout_reg <= 1'b0;
      end else begin
         hold_cnt_reg     <= hold_cnt_next;
         hold_timeout_reg <= (hold_cnt_next == HOLD_MAX);
      end
   end

   assign hold_timeout = hold_timeout_reg;

endmodule : stall_watchdog

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: priority stall vector with bubble insertion,
// registered multi-cycle flush/redirect for exceptions and ERET, watchdog and stall counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int                NSTAGE       = 6,
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] EXC_VEC      = ADDR_W'(DEFAULT_EXC_VEC),
   parameter int                FLUSH_CYCLES = 1,
   parameter int                MAX_HOLD     = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSTAGE-1:0] stall_req,
   input  logic              except_req,
   input  logic              eret_req,
   input  logic [ADDR_W-1:0] epc,
   output logic [NSTAGE-1:0] stall,
   output logic [NSTAGE-1:0] bubble,
   output logic              flush,
   output logic [ADDR_W-1:0] new_pc,
   output logic              hold_timeout,
   output logic [31:0]       stall_cnt
);

   localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

   ctrl_state_t       state_reg;
   ctrl_state_t       state_next;
   logic [FC_W-1:0]   flush_cnt_reg;
   logic [FC_W-1:0]   flush_cnt_next;
   logic [ADDR_W-1:0] new_pc_reg;
   logic [ADDR_W-1:0] new_pc_next;
   logic [31:0]       stall_cnt_reg;

   logic [NSTAGE-1:0] run_stall;
   logic [NSTAGE-1:0] run_bubble;
   logic [NSTAGE-1:0] stall_vec;
   logic [NSTAGE-1:0] bubble_vec;
   logic              redirect;

   // Every stage at or below the oldest requester freezes; the stage just above gets a NOP.
   generate
      for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_prio
         assign run_stall[gi] = |stall_req[NSTAGE-1:gi];
         if (gi == 0) begin : g_first
            assign run_bubble[gi] = 1'b0;
         end else begin : g_rest
            assign run_bubble[gi] = run_stall[gi-1] & ~run_stall[gi];
         end
      end
   endgenerate

   always_comb begin
      state_next     = state_reg;
      flush_cnt_next = flush_cnt_reg;
      new_pc_next    = new_pc_reg;
      stall_vec      = '0;
      bubble_vec     = '0;
      redirect       = 1'b0;
      case (state_reg)
         RUN: begin
            if (except_req || eret_req) begin
               redirect       = 1'b1;
               stall_vec      = '1;
               state_next     = FLUSH;
               flush_cnt_next = FC_LOAD;
               new_pc_next    = except_req ? EXC_VEC : epc;
            end else begin
               stall_vec  = run_stall;
               bubble_vec = run_bubble;
            end
         end
         FLUSH: begin
            flush_cnt_next = flush_cnt_reg - FC_W'(1);
            if (flush_cnt_reg == FC_W'(1)) begin
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= RUN;
         flush_cnt_reg <= '0;
         new_pc_reg    <= '0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         flush_cnt_reg <= flush_cnt_next;
         new_pc_reg    <= new_pc_next;
         if (stall_vec[0]) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end
      end
   end

   // A redirect counts as a stalled cycle but restarts the hold window.
   stall_watchdog #(
      .MAX_HOLD (MAX_HOLD)
   ) u_watchdog (
      .clk          (clk),
      .reset        (reset),
      .stall_active (stall_vec[0]),
      .clear        (~stall_vec[0] | redirect),
      .hold_timeout (hold_timeout)
   );

   // While reset is held the pipeline must see no freeze or NOP regardless of requests.
   assign stall     = reset ? stall_vec  : '0;
   assign bubble    = reset ? bubble_vec : '0;
   assign flush     = (state_reg == FLUSH);
   assign new_pc    = new_pc_reg;
   assign stall_cnt = stall_cnt_reg;

endmodule : pipe_ctrl
